// File: rtl/fir_sample_tx.sv
// Serial transmitter for FIR output samples: a small sample FIFO feeding an
// 8N1 frame generator (start bit, 8 data bits LSB first, stop bit).
module fir_sample_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BIT_LAST_C = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          in_ready_r;

    state_t        state_r;
    logic [BW-1:0] bit_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          busy_r;
    logic          frame_done_r;

    logic          push_s;
    logic          pop_s;
    logic          not_empty_s;
    logic          bit_end_s;

    assign push_s      = in_valid & in_ready_r;
    assign not_empty_s = (count_r != {CW{1'b0}});
    assign bit_end_s   = (bit_cnt_r == BIT_LAST_C);

    assign in_ready    = in_ready_r;
    assign tx          = tx_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;

    // Pop request: leaving IDLE, or chaining straight from STOP into the next START
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = not_empty_s;
            STOP:    pop_s = bit_end_s & not_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Sample storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // FIFO pointers and occupancy; in_ready is registered from the next count
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_nxt_s;
            in_ready_r <= (count_nxt_s != DEPTH_C);
        end
    end

    // Frame generator: the shift register holds the byte on the wire, so input
    // changes during a frame cannot disturb it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            bit_cnt_r    <= {BW{1'b0}};
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= {BW{1'b0}};
                    if (not_empty_s) begin
                        shift_r <= mem_r[rd_ptr_r];
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= START;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= {BW{1'b0}};
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                        state_r   <= DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        bit_cnt_r <= {BW{1'b0}};
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        bit_cnt_r    <= {BW{1'b0}};
                        frame_done_r <= 1'b1;
                        if (not_empty_s) begin
                            shift_r <= mem_r[rd_ptr_r];
                            tx_r    <= 1'b0;
                            state_r <= START;
                        end else begin
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_cnt_r <= {BW{1'b0}};
                    tx_r      <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_tx.sv
// Directed bench for fir_sample_tx: two instances (4 and 2 clocks per bit)
// share one stimulus; sel chooses which one the checks observe.
module tb_fir_sample_tx;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready4, tx4, busy4, fd4;
    logic       in_ready2, tx2, busy2, fd2;
    logic       sel;
    logic       tx_m, busy_m, fd_m, in_ready_m;
    int         pass_cnt;
    int         total_cnt;

    fir_sample_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready4), .tx(tx4), .busy(busy4), .frame_done(fd4)
    );

    fir_sample_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready2), .tx(tx2), .busy(busy2), .frame_done(fd2)
    );

    assign tx_m       = sel ? tx2       : tx4;
    assign busy_m     = sel ? busy2     : busy4;
    assign fd_m       = sel ? fd2       : fd4;
    assign in_ready_m = sel ? in_ready2 : in_ready4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Called one cycle into a frame (tx already low); ends at the edge after the stop bit
    task automatic check_frame(input string tag, input logic [9:0] pat, input int cpb,
                               input logic fd_first);
        for (int i = 0; i < 10 * cpb; i++) begin
            chk({tag, "_tx"}, tx_m, pat[i / cpb]);
            chk({tag, "_busy"}, busy_m, 1'b1);
            chk({tag, "_fd"}, fd_m, (i == 0) ? fd_first : 1'b0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        sel       = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        step();
        step();
        chk("rst_tx", tx_m, 1'b1);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_fd", fd_m, 1'b0);
        chk("rst_ready", in_ready_m, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_idle_tx", tx_m, 1'b1);
            chk("post_rst_idle_busy", busy_m, 1'b0);
        end

        // Single byte 0xA5: tx 0,1,0,1,0,0,1,0,1,1
        in_data  = 8'hA5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("a5_latency_tx", tx_m, 1'b1);
        chk("a5_latency_busy", busy_m, 1'b0);
        step();
        check_frame("a5", 10'b1101001010, 4, 1'b0);
        chk("a5_end_fd", fd_m, 1'b1);
        chk("a5_end_busy", busy_m, 1'b0);
        chk("a5_end_tx", tx_m, 1'b1);
        step();
        chk("a5_after_fd", fd_m, 1'b0);
        chk("a5_after_tx", tx_m, 1'b1);

        // Back-to-back 0x00 then 0xFF with no idle gap
        in_data  = 8'h00;
        in_valid = 1'b1;
        step();
        in_data = 8'hFF;
        step();
        in_valid = 1'b0;
        check_frame("b2b_00", 10'b1000000000, 4, 1'b0);
        check_frame("b2b_ff", 10'b1111111110, 4, 1'b1);
        chk("b2b_end_fd", fd_m, 1'b1);
        chk("b2b_end_busy", busy_m, 1'b0);
        step();
        chk("b2b_after_fd", fd_m, 1'b0);

        // Backpressure: 0x01..0x05 accepted, 0x06 waits for the first chained pop
        in_data  = 8'h01;
        in_valid = 1'b1;
        chk("bp_ready_01", in_ready_m, 1'b1);
        step();
        in_data = 8'h02;
        chk("bp_ready_02", in_ready_m, 1'b1);
        step();
        in_data = 8'h03;
        chk("bp_ready_03", in_ready_m, 1'b1);
        step();
        in_data = 8'h04;
        chk("bp_ready_04", in_ready_m, 1'b1);
        step();
        in_data = 8'h05;
        chk("bp_ready_05", in_ready_m, 1'b1);
        step();
        in_data = 8'h06;
        chk("bp_full_06", in_ready_m, 1'b0);
        for (int i = 0; i < 36; i++) begin
            step();
            chk("bp_hold_full", in_ready_m, 1'b0);
        end
        step();
        chk("bp_pop_fd", fd_m, 1'b1);
        chk("bp_pop_tx", tx_m, 1'b0);
        chk("bp_pop_ready", in_ready_m, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bp_06_taken_full", in_ready_m, 1'b0);
        for (int i = 0; i < 39; i++) begin
            step();
        end
        chk("bp_02_end_fd", fd_m, 1'b1);
        chk("bp_02_end_tx", tx_m, 1'b0);
        check_frame("bp_03", 10'b1000000110, 4, 1'b1);
        check_frame("bp_04", 10'b1000001000, 4, 1'b1);
        check_frame("bp_05", 10'b1000001010, 4, 1'b1);
        check_frame("bp_06", 10'b1000001100, 4, 1'b1);
        chk("bp_end_fd", fd_m, 1'b1);
        chk("bp_end_busy", busy_m, 1'b0);
        chk("bp_end_tx", tx_m, 1'b1);
        step();

        // Mid-frame reset during data bit 3 of 0x11 with 0x22, 0x33 queued
        in_data  = 8'h11;
        in_valid = 1'b1;
        step();
        in_data = 8'h22;
        step();
        in_data = 8'h33;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
        end
        chk("mid_busy_before", busy_m, 1'b1);
        chk("mid_bit3_tx", tx_m, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_tx", tx_m, 1'b1);
        chk("mid_rst_busy", busy_m, 1'b0);
        chk("mid_rst_ready", in_ready_m, 1'b1);
        chk("mid_rst_fd", fd_m, 1'b0);
        for (int i = 0; i < 60; i++) begin
            step();
            chk("mid_idle_tx", tx_m, 1'b1);
            chk("mid_idle_busy", busy_m, 1'b0);
        end

        // Minimum divisor: CLKS_PER_BIT=2, 0x3C
        sel      = 1'b1;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("c2_latency_tx", tx_m, 1'b1);
        step();
        check_frame("c2_3c", 10'b1001111000, 2, 1'b0);
        chk("c2_end_fd", fd_m, 1'b1);
        chk("c2_end_busy", busy_m, 1'b0);
        chk("c2_end_tx", tx_m, 1'b1);
        step();
        chk("c2_after_fd", fd_m, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
